// File: rtl/wb_ipi_pkg.sv
// ---------------------------------------------------------------------------
// wb_ipi_pkg
// Shared definitions for the inter-processor mailbox (wb_ipi_mailbox):
//   - register word offsets inside a core window
//   - STATUS register bit positions
//   - address bit ranges for window and register select
//   - Wishbone cycle-type code used for incrementing bursts
//   - bus handshake FSM state encoding
//   - reset value helper for the per-core TARGET registers
// ---------------------------------------------------------------------------
package wb_ipi_pkg;

  // Register word index inside a core window (address bits [3:2]).
  typedef enum logic [1:0] {
    REG_TARGET = 2'd0,
    REG_SEND   = 2'd1,
    REG_RECV   = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  // STATUS register layout.
  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_W   = 3;
  localparam int unsigned STAT_OVF       = 31;

  // Address decode ranges.
  localparam int unsigned WIN_MSB = 6;
  localparam int unsigned WIN_LSB = 5;
  localparam int unsigned REG_MSB = 3;
  localparam int unsigned REG_LSB = 2;

  // Incrementing-burst cycle type; any other code ends the burst.
  localparam logic [2:0] CTI_INCR = 3'b010;

  // Bus handshake states:
  //   S_IDLE  : no response on the bus, a new access may be accepted
  //   S_ACK   : ack or err is high, next access must wait one cycle
  //   S_BURST : ack is high for an incrementing beat, next beat may follow
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_BURST = 2'd2
  } bus_state_e;

  // Each core initially sends to its neighbour: (core + 1) mod ncores.
  function automatic logic [1:0] target_reset(input int unsigned core,
                                              input int unsigned ncores);
    return 2'((core + 1) % ncores);
  endfunction

endpackage

// File: rtl/wb_ipi_fifo.sv
// ---------------------------------------------------------------------------
// wb_ipi_fifo
// Per-core receive FIFO for the mailbox. Depth is 2**FIFO_AW words.
// Pointers carry one extra wrap bit so that full and empty are told apart
// by count = wr_ptr - rd_ptr (modulo 2**(FIFO_AW+1)).
// The head word is presented combinationally so a pop can return it in the
// same edge that retires it.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (pointers only)
//   push_i   in   write wdata_i at the tail; ignored when full
//   pop_i    in   retire the head; ignored when empty
//   wdata_i  in   DW  push data
//   rdata_o  out  DW  current head word
//   empty_o  out  FIFO holds no words
//   full_o   out  FIFO holds 2**FIFO_AW words
//   count_o  out  FIFO_AW+1  number of words held
// ---------------------------------------------------------------------------
module wb_ipi_fifo #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned DW      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DW-1:0]     wdata_i,
  output logic [DW-1:0]     rdata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [FIFO_AW:0]  count_o
);

  localparam int unsigned      DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_PTR = {1'b1, {FIFO_AW{1'b0}}};

  logic [DW-1:0]    mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == DEPTH_PTR);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a word is only ever read after it was pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[FIFO_AW-1:0]];

endmodule

// File: rtl/wb_ipi_mailbox.sv
// ---------------------------------------------------------------------------
// wb_ipi_mailbox
// Wishbone B3 slave giving every core a receive FIFO. A core pushes 32-bit
// messages into the FIFO of the core named by its TARGET register and pops
// its own FIFO through RECV. irq_o[c] is a level interrupt while core c has
// pending messages.
//
// Address map (byte address): bits [6:5] core window, bits [3:2] register
//   0x0 TARGET (RW)  destination core for SEND, bits [1:0]
//   0x4 SEND   (W)   push write data into FIFO of TARGET; reads 0
//   0x8 RECV   (R)   pop head of own FIFO; 0 when empty
//   0xC STATUS (R)   bit0 empty, bit1 full, [10:8] count, bit31 overflow
// Windows >= NUM_CORES answer with wb_err_o and change nothing.
//
// Optional feature macro: WB_IPI_OVERFLOW_EN
//   defined   : SEND into a full FIFO sets a sticky overflow flag of the
//               destination core; it is reported in STATUS bit31, keeps the
//               interrupt asserted and is cleared by writing 1 to bit31.
//   undefined : no overflow state; bit31 reads 0.
//
// Ports:
//   wb_clk_i  in   bus clock
//   wb_rst_i  in   asynchronous active-low reset
//   wb_adr_i  in   32  byte address
//   wb_dat_i  in   32  write data
//   wb_sel_i  in   4   byte selects (full-word accesses only, unused)
//   wb_we_i   in   write enable
//   wb_cyc_i  in   bus cycle
//   wb_stb_i  in   strobe
//   wb_cti_i  in   3   cycle type (010 continues a burst)
//   wb_bte_i  in   2   burst type (unused)
//   wb_dat_o  out  32  registered read data
//   wb_ack_o  out  registered acknowledge
//   wb_err_o  out  registered error
//   wb_rty_o  out  tied low
//   irq_o     out  NUM_CORES  per-core mailbox interrupt
// ---------------------------------------------------------------------------
module wb_ipi_mailbox
  import wb_ipi_pkg::*;
#(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic [NUM_CORES-1:0] irq_o
);

  // Two window-select bits give four addressable windows; windows without a
  // core are padded with constant views so the decode never indexes out of
  // range.
  localparam int unsigned MAX_WIN = 4;

  bus_state_e  state_q, state_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  logic [1:0]  win;
  reg_e        reg_sel;
  logic        win_ok;
  logic        accept;
  logic        wr_ok, rd_ok;
  logic        send_req;
  logic [1:0]  dest;

  logic [1:0]              tgt_w   [MAX_WIN];
  logic [31:0]             rdata_w [MAX_WIN];
  logic [STAT_COUNT_W-1:0] cnt_w   [MAX_WIN];
  logic [MAX_WIN-1:0]      empty_w, full_w, ovf_w;

  logic unused_inputs;
  assign unused_inputs = ^{wb_sel_i, wb_bte_i, wb_adr_i[31:7], wb_adr_i[4],
                           wb_adr_i[1:0]};

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  assign win     = wb_adr_i[WIN_MSB:WIN_LSB];
  assign reg_sel = reg_e'(wb_adr_i[REG_MSB:REG_LSB]);
  assign win_ok  = (32'(win) < NUM_CORES);

  // A beat is taken when the bus is quiet, or back-to-back while an
  // incrementing burst is being acknowledged.
  assign accept = wb_cyc_i & wb_stb_i &
                  ((state_q == S_IDLE) | (state_q == S_BURST));

  assign wr_ok    = accept & win_ok & wb_we_i;
  assign rd_ok    = accept & win_ok & ~wb_we_i;
  assign send_req = wr_ok & (reg_sel == REG_SEND);
  assign dest     = tgt_w[win];

  // -------------------------------------------------------------------------
  // Per-core state: FIFO, TARGET register, optional overflow flag
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < MAX_WIN; gi++) begin : g_win
    if (gi < NUM_CORES) begin : g_core
      logic             push, pop, tgt_we;
      logic [FIFO_AW:0] count;
      logic [1:0]       tgt_q, tgt_d;

      assign push   = send_req & (dest == 2'(gi));
      assign pop    = rd_ok & (reg_sel == REG_RECV) & (win == 2'(gi));
      // Out-of-range destinations are acked but leave TARGET untouched.
      assign tgt_we = wr_ok & (reg_sel == REG_TARGET) & (win == 2'(gi)) &
                      (wb_dat_i < NUM_CORES);

      wb_ipi_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (32)
      ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wb_dat_i),
        .rdata_o (rdata_w[gi]),
        .empty_o (empty_w[gi]),
        .full_o  (full_w[gi]),
        .count_o (count)
      );

      assign cnt_w[gi] = STAT_COUNT_W'(count);

      assign tgt_d = tgt_we ? wb_dat_i[1:0] : tgt_q;

      always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
          tgt_q <= target_reset(gi, NUM_CORES);
        end else begin
          tgt_q <= tgt_d;
        end
      end

      assign tgt_w[gi] = tgt_q;

`ifdef WB_IPI_OVERFLOW_EN
      logic ovf_q, ovf_d, ovf_clr;

      assign ovf_clr = wr_ok & (reg_sel == REG_STATUS) & (win == 2'(gi)) &
                       wb_dat_i[STAT_OVF];

      // Set and clear come from different accesses, so they never collide.
      always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
          ovf_d = 1'b0;
        end else if (push & full_w[gi]) begin
          ovf_d = 1'b1;
        end
      end

      always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf_w[gi] = ovf_q;
`else
      assign ovf_w[gi] = 1'b0;
`endif

      // FIFO state changes at the accept edge, so the interrupt moves in the
      // same cycle as the corresponding ack.
      assign irq_o[gi] = ~empty_w[gi] | ovf_w[gi];
    end else begin : g_pad
      assign tgt_w[gi]   = 2'd0;
      assign rdata_w[gi] = 32'd0;
      assign cnt_w[gi]   = '0;
      assign empty_w[gi] = 1'b1;
      assign full_w[gi]  = 1'b0;
      assign ovf_w[gi]   = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE, S_BURST: begin
        if (accept) begin
          // Error responses never continue a burst.
          state_d = (win_ok && (wb_cti_i == CTI_INCR)) ? S_BURST : S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake FSM: outputs (next values of the registered bus outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    ack_d = accept & win_ok;
    err_d = accept & ~win_ok;
    dat_d = '0;
    if (rd_ok) begin
      case (reg_sel)
        REG_TARGET: dat_d = {30'd0, tgt_w[win]};
        REG_RECV:   dat_d = empty_w[win] ? 32'd0 : rdata_w[win];
        REG_STATUS: begin
          dat_d[STAT_EMPTY]                     = empty_w[win];
          dat_d[STAT_FULL]                      = full_w[win];
          dat_d[STAT_COUNT_LSB +: STAT_COUNT_W] = cnt_w[win];
          dat_d[STAT_OVF]                       = ovf_w[win];
        end
        default:    dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      if (accept) begin
        dat_q <= dat_d;
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: doc/wb_ipi_mailbox.md
# wb_ipi_mailbox

Wishbone B3 slave providing inter-processor mailboxes for the dual-core mor1kx system. It sits as an additional slave on the shared `wb_bus_b3` and drives the per-core `irq_i` lines, which are currently tied to zero. Any core can push 32-bit messages into another core's receive FIFO. The receiving core gets a level interrupt while its FIFO is non-empty and pops messages by register read.

## Interface
- `NUM_CORES`, 2: number of mailboxes, range 2..4.
- `FIFO_AW`, 2: log2 of FIFO depth per core; depth is 4 at the default.
- `wb_clk_i`  in  1  bus clock; all logic is on its rising edge.
- `wb_rst_i`  in  1  reset, **asynchronous, active-low**.
- `wb_adr_i`  in  32  byte address; bits [6:5] select the core window `c`, bits [3:2] select the register; other bits are ignored.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte selects; ignored, all accesses are full-word.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`, `wb_stb_i`  in  1 each  cycle and strobe.
- `wb_cti_i`  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst.
- `wb_bte_i`  in  2  burst type; ignored.
- `wb_dat_o`  out  32  registered read data.
- `wb_ack_o`  out  1  registered acknowledge.
- `wb_err_o`  out  1  registered error.
- `wb_rty_o`  out  1  constant 0.
- `irq_o`  out  NUM_CORES  bit `c` is high while core `c`'s FIFO is non-empty.

## Operation
- Registers in window `c`:
  - 0x0 TARGET (RW): bits [1:0] hold the destination core index for SEND.
  - 0x4 SEND (W): pushes `wb_dat_i` into the FIFO of core TARGET[c]. Reads return 0.
  - 0x8 RECV (R): pops the head of core `c`'s FIFO and returns it. If the FIFO is empty, returns 0 and nothing is popped. Writes are ignored.
  - 0xC STATUS (R): bit0 = empty, bit1 = full, bits [10:8] = count, bit31 = overflow (feature-gated). Writing 1 to bit31 clears overflow.
- Window index `c >= NUM_CORES`: respond with `wb_err_o` instead of `wb_ack_o`; no state changes.
- A write to TARGET with a value `>= NUM_CORES` is acked, but the TARGET register keeps its old value.
- SEND when the destination FIFO is full: acked; the data is dropped.
- Only one access is handled per cycle, so a push and a pop on the same FIFO never coincide.
- Reset values:
  - `wb_ack_o`, `wb_err_o`, `wb_dat_o` = 0.
  - All FIFOs empty; `irq_o` = 0; overflow flags = 0.
  - TARGET[c] = (c+1) mod NUM_CORES.
- Reset asserted mid-transaction:
  - All state is cleared immediately.
  - Any pending ack is lost; the master re-issues the access.

## Timing
- Accept condition: an access is accepted at rising edge E when `wb_cyc_i & wb_stb_i` and any one of the following holds:
  - `!wb_ack_o & !wb_err_o`, or
  - `wb_ack_o` is high and the previous beat was accepted with cti=010.
- On acceptance at edge E:
  - Pushes, pops and register writes commit at E.
  - `wb_dat_o` is loaded at E.
  - `wb_ack_o` (or `wb_err_o`) is high for the cycle following E.
- Classic access: 1-cycle latency. Ack is high for exactly one cycle, then low for at least one cycle.
- Burst (cti=010): acks are back-to-back, one beat per cycle. Each beat pops or pushes once.
- A beat with cti=111 is the last beat; ack drops after it.
- Master aborts a burst by dropping `wb_stb_i`: ack deasserts on the next edge and no further beats are committed.
- `irq_o[c]` rises in the same cycle as the SEND ack that makes the FIFO non-empty. It falls in the same cycle as the RECV ack that empties it.
- Count arithmetic:
  - Pointers are FIFO_AW+1 bits; count = wr_ptr - rd_ptr, modulo 2^(FIFO_AW+1).
  - Full when count == 2^FIFO_AW.
  - Pointers wrap naturally.

## Configuration
- Macro: `WB_IPI_OVERFLOW_EN`.
- Defined:
  - A SEND to a full FIFO sets the destination core's sticky overflow bit (STATUS bit31).
  - `irq_o[c]` = non-empty OR overflow[c].
  - A write of 1 to bit31 clears the flag, effective after the ack edge.
- Undefined:
  - No overflow state; STATUS bit31 reads 0; writes to bit31 are ignored.
  - `irq_o[c]` = non-empty only.

## Structure
- Package `wb_ipi_pkg` holds:
  - Register offsets: TARGET=0, SEND=1, RECV=2, STATUS=3 (word index).
  - STATUS bit positions: EMPTY=0, FULL=1, COUNT_LSB=8, OVF=31.
  - Window select bit range [6:5].
- Sub-module `wb_ipi_fifo`: a synchronous FIFO parameterised by FIFO_AW, with ports push, pop, wdata, rdata, empty, full, count. It is instantiated NUM_CORES times via generate.
- The top level contains the Wishbone decode, the accept/ack FSM (IDLE, ACK, BURST) and the TARGET registers.

## Test plan
- Reset → ack/err/irq low; STATUS reads 0x00000001; core0 TARGET reads 1 and core1 TARGET reads 0.
- Core0 writes SEND 0xDEADBEEF → `irq_o` = 2'b10 in the ack cycle; a core1 RECV returns 0xDEADBEEF and `irq_o` returns to 0.
- Push 5 words into core1 with FIFO_AW=2:
  - STATUS shows full, count=4; the 5th word is dropped.
  - With `WB_IPI_OVERFLOW_EN`, bit31 = 1 and irq stays high after draining until bit31 is written with 1.
- 4-beat burst read (cti 010,010,010,111) of core1 RECV after 4 pushes → 4 consecutive ack cycles returning the data in push order; FIFO ends empty.
- Access to window 3 with NUM_CORES=2 → `wb_err_o` for one cycle, no ack, FIFOs unchanged.
- Reset asserted during a burst, after 2 beats → outputs clear asynchronously; after release STATUS reads empty.
